// File: rtl/sync_merge_n_if.sv
// Handshake bundle between N_CH upstream 4-phase requesters and one downstream
// channel, with grant-index and busy status.
interface sync_merge_n_if #(
   parameter int N_CH  = 2,
   parameter int IDX_W = $clog2(N_CH)
);
   logic [N_CH-1:0]  req_in;
   logic [N_CH-1:0]  ack_out;
   logic [N_CH-1:0]  mask;
   logic             req_out;
   logic             ack_in;
   logic [IDX_W-1:0] sel_out;
   logic             busy;

   modport master (
      output req_in, mask, ack_in,
      input  ack_out, req_out, sel_out, busy
   );

   modport slave (
      input  req_in, mask, ack_in,
      output ack_out, req_out, sel_out, busy
   );
endinterface

// File: rtl/sync_merge_n.sv
// Merges N_CH asynchronous 4-phase request/ack channels onto one downstream
// 4-phase channel, either sharing one cycle (MODE 0) or round-robin (MODE 1).
module sync_merge_n #(
   parameter int N_CH        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0,
   parameter int IDX_W       = $clog2(N_CH)
) (
   input  logic         clk,
   input  logic         reset,
   sync_merge_n_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      STARTING  = 2'b01,
      STABLE    = 2'b10,
      DISABLING = 2'b11
   } state_t;

   localparam int SW = N_CH + 1;

   // Requests and downstream ack share one synchroniser chain: bit N_CH is ack.
   logic [SW-1:0]   sync_q [SYNC_STAGES];
   logic [N_CH-1:0] req_s;
   logic            ack_s;

   // NOTE: the synchroniser array is cleared explicitly on reset so that no
   // stale request can leak into the FSM after reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value, which is what makes this a shift chain.
         sync_q[0] <= {bus.ack_in, bus.req_in};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1][N_CH-1:0];
   assign ack_s = sync_q[SYNC_STAGES-1][N_CH];

   state_t           state_q, state_d;
   logic             req_q, req_d;
   logic [N_CH-1:0]  ack_q, ack_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             busy_q, busy_d;

   logic [N_CH-1:0]  elig;
   logic [N_CH-1:0]  keep;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;

   assign elig = req_s & bus.mask;
   // Live acks survive a mask drop; only a fallen request releases them.
   assign keep = req_s & (bus.mask | ack_q);

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int               off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_CH) sum = sum - N_CH;
      return sum[IDX_W-1:0];
   endfunction

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!win_found && elig[wrap_add(ptr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(ptr_q, k);
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block is given a hold value first, so no
      // path through the case statement can infer a latch.
      state_d = state_q;
      req_d   = req_q;
      ack_d   = ack_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;

      if (MODE == 0) begin
         case (state_q)
            IDLE: begin
               ack_d = '0;
               if (|elig) begin
                  req_d   = 1'b1;
                  state_d = STARTING;
               end
            end
            STARTING: begin
               if (ack_s) begin
                  ack_d   = elig;
                  state_d = STABLE;
               end
            end
            STABLE: begin
               if (|keep) begin
                  ack_d = keep;
               end else begin
                  req_d   = 1'b0;
                  state_d = DISABLING;
               end
            end
            DISABLING: begin
               if (!ack_s) begin
                  ack_d   = '0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               ack_d = '0;
               if (win_found) begin
                  sel_d   = win_idx;
                  req_d   = 1'b1;
                  state_d = STARTING;
               end
            end
            STARTING: begin
               if (ack_s) begin
                  ack_d = '0;
                  // A requester that withdrew before the ack is never acked.
                  if (req_s[sel_q]) ack_d[sel_q] = 1'b1;
                  state_d = STABLE;
               end
            end
            STABLE: begin
               if (!req_s[sel_q]) begin
                  req_d   = 1'b0;
                  state_d = DISABLING;
               end
            end
            DISABLING: begin
               if (!ack_s) begin
                  ack_d   = '0;
                  ptr_d   = wrap_add(sel_q, 1);
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         ack_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.req_out = req_q;
   assign bus.ack_out = ack_q;
   assign bus.sel_out = sel_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sync_merge_n.sv
// Bench for sync_merge_n: a 2-channel merge instance and a 4-channel
// round-robin instance, with queue-based expected acks and grant order.
module tb_sync_merge_n;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [1:0] exp0_q[$];
   int         exp1_q[$];

   always #5 clk = ~clk;

   sync_merge_n_if #(.N_CH(2)) m0 ();
   sync_merge_n_if #(.N_CH(4)) m1 ();

   sync_merge_n #(.N_CH(2), .SYNC_STAGES(2), .MODE(0)) dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (m0)
   );

   sync_merge_n #(.N_CH(4), .SYNC_STAGES(2), .MODE(1)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (m1)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst0 = 1'b1; rst1 = 1'b1;
      m0.req_in = '0; m0.ack_in = 1'b0; m0.mask = 2'b11;
      m1.req_in = '0; m1.ack_in = 1'b0; m1.mask = 4'b1111;
      tick(3);
      n_checks++; if (m0.req_out !== 1'b0) begin n_fail++; $display("FAIL reset0_req_out: got %b want 0", m0.req_out); end
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL reset0_ack_out: got %b want 00", m0.ack_out); end
      n_checks++; if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL reset0_busy: got %b want 0", m0.busy); end
      n_checks++; if (m0.sel_out !== 1'b0) begin n_fail++; $display("FAIL reset0_sel: got %b want 0", m0.sel_out); end
      n_checks++; if (m1.req_out !== 1'b0) begin n_fail++; $display("FAIL reset1_req_out: got %b want 0", m1.req_out); end
      n_checks++; if (m1.ack_out !== 4'b0000) begin n_fail++; $display("FAIL reset1_ack_out: got %b want 0000", m1.ack_out); end
      n_checks++; if (m1.busy !== 1'b0) begin n_fail++; $display("FAIL reset1_busy: got %b want 0", m1.busy); end
      n_checks++; if (m1.sel_out !== 2'b00) begin n_fail++; $display("FAIL reset1_sel: got %b want 00", m1.sel_out); end
      rst0 = 1'b0; rst1 = 1'b0;
      tick(1);
   endtask

   // Single requester: three-edge latency on request and ack, then teardown.
   task automatic test_latency;
      m0.req_in = 2'b01;
      tick(2);
      n_checks++; if (m0.req_out !== 1'b0) begin n_fail++; $display("FAIL lat_req_early: got %b want 0", m0.req_out); end
      tick(1);
      n_checks++; if (m0.req_out !== 1'b1) begin n_fail++; $display("FAIL lat_req_rise: got %b want 1", m0.req_out); end
      n_checks++; if (m0.busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %b want 1", m0.busy); end
      m0.ack_in = 1'b1;
      tick(2);
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL lat_ack_early: got %b want 00", m0.ack_out); end
      tick(1);
      n_checks++; if (m0.ack_out !== 2'b01) begin n_fail++; $display("FAIL lat_ack_rise: got %b want 01", m0.ack_out); end
      m0.req_in = 2'b00;
      tick(3);
      n_checks++; if (m0.req_out !== 1'b0) begin n_fail++; $display("FAIL lat_req_fall: got %b want 0", m0.req_out); end
      n_checks++; if (m0.ack_out !== 2'b01) begin n_fail++; $display("FAIL lat_ack_held: got %b want 01", m0.ack_out); end
      m0.ack_in = 1'b0;
      tick(3);
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL lat_ack_fall: got %b want 00", m0.ack_out); end
      n_checks++; if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_end: got %b want 0", m0.busy); end
   endtask

   // Late joiner acked, early leaver released, downstream request kept.
   task automatic test_join_leave;
      logic [1:0] exp;
      m0.req_in = 2'b01;
      tick(3);
      m0.ack_in = 1'b1; exp0_q.push_back(2'b01);
      tick(3);
      exp = exp0_q.pop_front();
      n_checks++; if (m0.ack_out !== exp) begin n_fail++; $display("FAIL join_first: got %b want %b", m0.ack_out, exp); end
      m0.req_in = 2'b11; exp0_q.push_back(2'b11);
      tick(3);
      exp = exp0_q.pop_front();
      n_checks++; if (m0.ack_out !== exp) begin n_fail++; $display("FAIL join_late: got %b want %b", m0.ack_out, exp); end
      m0.req_in = 2'b10; exp0_q.push_back(2'b10);
      tick(3);
      exp = exp0_q.pop_front();
      n_checks++; if (m0.ack_out !== exp) begin n_fail++; $display("FAIL leave_ack: got %b want %b", m0.ack_out, exp); end
      n_checks++; if (m0.req_out !== 1'b1) begin n_fail++; $display("FAIL leave_req_out: got %b want 1", m0.req_out); end
      m0.req_in = 2'b00;
      tick(3);
      m0.ack_in = 1'b0;
      tick(3);
      n_checks++; if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL join_idle: got %b want 0", m0.busy); end
   endtask

   // Masked channel ignored at start; unmasking-off never drops a live ack.
   task automatic test_mask;
      m0.mask = 2'b10; m0.req_in = 2'b11;
      tick(3);
      n_checks++; if (m0.req_out !== 1'b1) begin n_fail++; $display("FAIL mask_req_out: got %b want 1", m0.req_out); end
      m0.ack_in = 1'b1;
      tick(3);
      n_checks++; if (m0.ack_out !== 2'b10) begin n_fail++; $display("FAIL mask_ack: got %b want 10", m0.ack_out); end
      m0.mask = 2'b00;
      tick(3);
      n_checks++; if (m0.ack_out !== 2'b10) begin n_fail++; $display("FAIL mask_live_ack: got %b want 10", m0.ack_out); end
      m0.req_in = 2'b01;
      tick(3);
      n_checks++; if (m0.req_out !== 1'b0) begin n_fail++; $display("FAIL mask_req_fall: got %b want 0", m0.req_out); end
      n_checks++; if (m0.ack_out !== 2'b10) begin n_fail++; $display("FAIL mask_ack_hold: got %b want 10", m0.ack_out); end
      m0.ack_in = 1'b0;
      tick(3);
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL mask_ack_fall: got %b want 00", m0.ack_out); end
      n_checks++; if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL mask_idle: got %b want 0", m0.busy); end
      m0.req_in = 2'b00;
      tick(3);
      m0.mask = 2'b11;
      tick(1);
   endtask

   // Request withdrawn before downstream ack: cycle completes with no ack.
   task automatic test_drop_starting;
      m0.req_in = 2'b01;
      tick(3);
      m0.req_in = 2'b00;
      tick(3);
      m0.ack_in = 1'b1;
      tick(3);
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL drop_ack: got %b want 00", m0.ack_out); end
      n_checks++; if (m0.req_out !== 1'b1) begin n_fail++; $display("FAIL drop_stable_req: got %b want 1", m0.req_out); end
      tick(1);
      n_checks++; if (m0.req_out !== 1'b0) begin n_fail++; $display("FAIL drop_req_fall: got %b want 0", m0.req_out); end
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL drop_ack_dis: got %b want 00", m0.ack_out); end
      m0.ack_in = 1'b0;
      tick(3);
      n_checks++; if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b want 0", m0.busy); end
   endtask

   task automatic test_reset_mid0;
      m0.req_in = 2'b11;
      tick(3);
      m0.ack_in = 1'b1;
      tick(3);
      n_checks++; if (m0.ack_out !== 2'b11) begin n_fail++; $display("FAIL rmid_pre_ack: got %b want 11", m0.ack_out); end
      rst0 = 1'b1;
      tick(1);
      n_checks++; if (m0.req_out !== 1'b0) begin n_fail++; $display("FAIL rmid_req_out: got %b want 0", m0.req_out); end
      n_checks++; if (m0.ack_out !== 2'b00) begin n_fail++; $display("FAIL rmid_ack: got %b want 00", m0.ack_out); end
      n_checks++; if (m0.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", m0.busy); end
      n_checks++; if (m0.sel_out !== 1'b0) begin n_fail++; $display("FAIL rmid_sel: got %b want 0", m0.sel_out); end
      m0.req_in = 2'b00; m0.ack_in = 1'b0;
      tick(3);
      rst0 = 1'b0;
      tick(1);
   endtask

   // Persistent 4-phase requesters and an auto-acking downstream; each new
   // grant is compared against the next expected channel from exp1_q.
   task automatic run_rr(input logic [3:0] msk);
      logic [3:0] prev;
      logic [3:0] onehot;
      int         exp;
      int         cyc;
      m1.mask = msk;
      prev = m1.ack_out;
      cyc = 0;
      while (exp1_q.size() > 0 && cyc < 800) begin
         m1.req_in = ~m1.ack_out;
         m1.ack_in = m1.req_out;
         tick(1);
         cyc++;
         n_checks++; if (!$onehot0(m1.ack_out)) begin n_fail++; $display("FAIL rr_onehot0: got %b want at most one bit", m1.ack_out); end
         if (m1.ack_out != 4'b0000 && prev == 4'b0000) begin
            exp = exp1_q.pop_front();
            onehot = 4'b0001 << exp;
            n_checks++; if (m1.sel_out !== 2'(exp)) begin n_fail++; $display("FAIL rr_sel: got %0d want %0d", m1.sel_out, exp); end
            n_checks++; if (m1.ack_out !== onehot) begin n_fail++; $display("FAIL rr_ack: got %b want %b", m1.ack_out, onehot); end
         end
         prev = m1.ack_out;
      end
      n_checks++; if (exp1_q.size() != 0) begin n_fail++; $display("FAIL rr_timeout: got %0d grants pending want 0", exp1_q.size()); exp1_q.delete(); end
   endtask

   task automatic test_rr;
      exp1_q.push_back(0); exp1_q.push_back(1); exp1_q.push_back(2);
      exp1_q.push_back(3); exp1_q.push_back(0);
      run_rr(4'b1111);
   endtask

   task automatic test_rr_reset;
      exp1_q.push_back(1);
      run_rr(4'b1111);
      rst1 = 1'b1;
      tick(1);
      n_checks++; if (m1.sel_out !== 2'b00) begin n_fail++; $display("FAIL rr_rst_sel: got %b want 00", m1.sel_out); end
      n_checks++; if (m1.ack_out !== 4'b0000) begin n_fail++; $display("FAIL rr_rst_ack: got %b want 0000", m1.ack_out); end
      n_checks++; if (m1.req_out !== 1'b0) begin n_fail++; $display("FAIL rr_rst_req: got %b want 0", m1.req_out); end
      n_checks++; if (m1.busy !== 1'b0) begin n_fail++; $display("FAIL rr_rst_busy: got %b want 0", m1.busy); end
      m1.req_in = '0; m1.ack_in = 1'b0;
      tick(3);
      rst1 = 1'b0;
      tick(1);
   endtask

   task automatic test_rr_mask;
      exp1_q.push_back(0); exp1_q.push_back(1);
      exp1_q.push_back(3); exp1_q.push_back(0);
      run_rr(4'b1011);
      rst1 = 1'b1;
      m1.req_in = '0; m1.ack_in = 1'b0; m1.mask = 4'b1111;
      tick(3);
      rst1 = 1'b0;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_join_leave();
      test_mask();
      test_drop_starting();
      test_reset_mid0();
      test_rr();
      test_rr_reset();
      test_rr_mask();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sync_merge_n.md
SYNC_MERGE_N -- requirements
Module: sync_merge_n

Interface
REQ-001 Parameter N_CH, default 2: number of 4-phase input request/ack channels (>=2).
REQ-002 Parameter SYNC_STAGES, default 2: flop stages per synchroniser (>=2).
REQ-003 Parameter MODE, default 0: 0 = merge (all requesters share one output cycle); 1 = round-robin arbitrated (one channel per output cycle).
REQ-004 Parameter IDX_W, default $clog2(N_CH): width of sel_out.
REQ-005 clk  input  1  single free-running clock; all flops rise-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_in  input  N_CH  asynchronous 4-phase requests, one per channel.
REQ-008 ack_out  output  N_CH  registered acks, one per channel.
REQ-009 req_out  output  1  registered merged request to downstream.
REQ-010 ack_in  input  1  asynchronous downstream ack.
REQ-011 mask  input  N_CH  synchronous channel enable; 0 = new requests on that channel ignored.
REQ-012 sel_out  output  IDX_W  registered index of the granted channel (MODE 1); held 0 in MODE 0.
REQ-013 busy  output  1  registered; 1 whenever FSM is not IDLE.

Function
REQ-014 req_in[i] and ack_in each SHALL pass through SYNC_STAGES flops giving req_s[i], ack_s; FSM uses only synchronised values.
REQ-015 FSM states SHALL be IDLE=2'b00, STARTING=2'b01, STABLE=2'b10, DISABLING=2'b11; state register updates every clock.
REQ-016 Eligible set SHALL be elig = req_s & mask.
REQ-017 MODE 0, IDLE: ack_out=0; if |elig -> req_out<=1, STARTING; else stay.
REQ-018 MODE 0, STARTING: req_out=1; when ack_s=1 -> ack_out<=elig, STABLE; else ack_out held.
REQ-019 MODE 0, STABLE: ack_out[i]<=req_s[i] & (mask[i] | ack_out[i]) (late joiners acked, leavers released, mask never drops a live ack); when no bit of that term is 1 -> req_out<=0, ack_out held, DISABLING.
REQ-020 MODE 0, DISABLING: req_out=0; when ack_s=0 -> ack_out<=0, IDLE; else hold.
REQ-021 MODE 1, IDLE: winner = first i with elig[i]=1 scanning ptr, ptr+1, ... mod N_CH; if found -> sel_out<=winner, req_out<=1, STARTING.
REQ-022 MODE 1, STARTING: when ack_s=1 -> ack_out[sel_out]<=1, STABLE; all other ack_out bits stay 0 throughout the grant.
REQ-023 MODE 1, STABLE: when req_s[sel_out]=0 -> req_out<=0, DISABLING; other requests queue, mask ignored for the granted channel.
REQ-024 MODE 1, DISABLING: when ack_s=0 -> ack_out<=0, ptr<=(sel_out==N_CH-1)?0:sel_out+1, IDLE.
REQ-025 Latency: req_out SHALL rise on the (SYNC_STAGES+1)th rising edge after req_in first meets setup in IDLE; ack_out on the (SYNC_STAGES+1)th edge after ack_in rises in STARTING.
REQ-026 Simultaneous requests: MODE 0 acks all eligible in the same cycle; MODE 1 resolves by rotation from ptr, no starvation (any persistently requesting unmasked channel granted within N_CH output cycles).
REQ-027 ack_out[i] SHALL never fall while req_s[i]=1, and never rise while req_out=0.
REQ-028 Request dropped during STARTING (MODE 0: elig=0; MODE 1: req_s[sel]=0) SHALL still complete the downstream cycle: STARTING->STABLE->DISABLING, its ack_out bit not asserted.

Reset
REQ-029 With reset=1 at a clock edge: state=IDLE, req_out=0, ack_out=0, sel_out=0, busy=0, ptr=0, all synchroniser flops=0.
REQ-030 Reset asserted mid-operation SHALL take effect on the next edge regardless of state; no handshake completion is attempted.

Verification
REQ-031 MODE 0, N_CH=2, SYNC_STAGES=2: req_in=01 -> req_out=1 after 3 edges; ack_in=1 -> ack_out=01 after 3 edges; req_in=00 -> req_out=0; ack_in=0 -> ack_out=00, busy=0.
REQ-032 MODE 0: req_in=01 in STABLE, then req_in=11 -> ack_out=11; req_in[0] drops -> ack_out=10, req_out stays 1.
REQ-033 MODE 1, N_CH=4: req_in=1111 held, downstream auto-acking -> sel_out sequence 0,1,2,3,0; ack_out one-hot each cycle.
REQ-034 mask=10, req_in=11 in IDLE (MODE 0) -> only ack_out=10; mask cleared on bit 1 in STABLE -> ack_out[1] stays 1 until req_in[1]=0.
REQ-035 reset=1 in STABLE with ack_out=11 -> next edge req_out=0, ack_out=00, busy=0, sel_out=0.
